// File: rtl/hdmi_axi_addr_gen.sv
// Read-command generator for HDMI scan-out: walks a frame buffer line by line in bursts.
// Define HDMI_AXI_ADDR_GEN_VFLIP_EN to read the frame bottom-up (vertical flip).
module hdmi_axi_addr_gen #(
  parameter int unsigned X_SIZE          = 1280,
  parameter int unsigned Y_SIZE          = 720,
  parameter int unsigned BYTES_PER_PIXEL = 4,
  parameter int unsigned BURST_WORDS     = 256,
  parameter int unsigned NUM_BUFFERS     = 2,
  parameter logic [31:0] BUF_BASE        = 32'h0000_0000,
  parameter logic [31:0] BUF_STRIDE      = 32'h0200_0000,
  parameter int unsigned LINE_PITCH      = X_SIZE * BYTES_PER_PIXEL,
  parameter int unsigned FIFO_THRESH     = 6400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  buf_sel,
  input  logic [31:0] fifo_available,
  input  logic        busy,
  output logic        kick,
  output logic [31:0] read_addr,
  output logic [31:0] read_num,
  output logic        frame_active,
  output logic        line_done,
  output logic        frame_done,
  output logic [15:0] cur_line
);

  typedef enum logic [1:0] {IDLE, GATE, ISSUE, WAIT} state_t;

  localparam logic [1:0] MAX_BUF = 2'(NUM_BUFFERS - 1);

  state_t      state;
  logic [1:0]  buf_q;
  logic [15:0] line;
  logic [31:0] column;
  logic        abort_pending;

  logic [31:0] remain;
  logic [31:0] next_num;
  logic [31:0] mem_line;
  logic [31:0] next_addr;
  logic [31:0] column_next;
  logic        line_end;
  logic        frame_end;

  // Next command is derived from line/column; the end tests use the command in flight.
  always_comb begin
    remain      = X_SIZE - column;
    next_num    = (remain < BURST_WORDS) ? remain : BURST_WORDS;
`ifdef HDMI_AXI_ADDR_GEN_VFLIP_EN
    mem_line    = Y_SIZE - 1 - 32'(line);
`else
    mem_line    = 32'(line);
`endif
    next_addr   = BUF_BASE + 32'(buf_q) * BUF_STRIDE + mem_line * LINE_PITCH
                + column * BYTES_PER_PIXEL;
    column_next = column + read_num;
    line_end    = (column_next >= X_SIZE);
    frame_end   = line_end && (32'(line) == Y_SIZE - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      kick          <= 1'b0;
      frame_active  <= 1'b0;
      line_done     <= 1'b0;
      frame_done    <= 1'b0;
      read_addr     <= BUF_BASE;
      read_num      <= 32'd0;
      line          <= 16'd0;
      column        <= 32'd0;
      buf_q         <= 2'd0;
      abort_pending <= 1'b0;
    end else begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state         <= GATE;
            frame_active  <= 1'b1;
            buf_q         <= (buf_sel > MAX_BUF) ? MAX_BUF : buf_sel;
            line          <= 16'd0;
            column        <= 32'd0;
            abort_pending <= 1'b0;
          end
        end
        GATE: begin
          if (abort) begin
            state        <= IDLE;
            frame_active <= 1'b0;
          end else if (!busy && (fifo_available < FIFO_THRESH)) begin
            state     <= ISSUE;
            kick      <= 1'b1;
            read_addr <= next_addr;
            read_num  <= next_num;
          end
        end
        ISSUE: begin
          if (abort) begin
            state        <= IDLE;
            kick         <= 1'b0;
            frame_active <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // An abort here must still see its command accepted before letting go.
          if (busy) begin
            kick <= 1'b0;
            if (abort || abort_pending) begin
              state         <= IDLE;
              frame_active  <= 1'b0;
              abort_pending <= 1'b0;
            end else begin
              if (line_end) begin
                column    <= 32'd0;
                line      <= line + 16'd1;
                line_done <= 1'b1;
              end else begin
                column <= column_next;
              end
              if (frame_end) begin
                frame_done   <= 1'b1;
                frame_active <= 1'b0;
                state        <= IDLE;
              end else begin
                state <= GATE;
              end
            end
          end else if (abort) begin
            abort_pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cur_line = line;

endmodule

// File: tb/tb_hdmi_axi_addr_gen.sv
// Self-checking bench for hdmi_axi_addr_gen: fixed command table, corner sequences and
// randomized frames compared against a plain-arithmetic command-list model.
module tb_hdmi_axi_addr_gen;

  localparam int unsigned X      = 600;
  localparam int unsigned Y      = 2;
  localparam int unsigned BPP    = 4;
  localparam int unsigned BURST  = 256;
  localparam int unsigned NB     = 2;
  localparam logic [31:0] BASE   = 32'h0010_0000;
  localparam logic [31:0] STRIDE = 32'h0200_0000;
  localparam int unsigned PITCH  = 2400;
  localparam int unsigned THRESH = 6400;

`ifdef HDMI_AXI_ADDR_GEN_VFLIP_EN
  localparam logic [31:0] LO0 = 32'h960;
  localparam logic [31:0] LO1 = 32'h0;
`else
  localparam logic [31:0] LO0 = 32'h0;
  localparam logic [31:0] LO1 = 32'h960;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  buf_sel;
  logic [31:0] fifo_available;
  logic        busy;
  logic        kick;
  logic [31:0] read_addr;
  logic [31:0] read_num;
  logic        frame_active;
  logic        line_done;
  logic        frame_done;
  logic [15:0] cur_line;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] num;
    logic [15:0] line;
    logic        ld;
    logic        fd;
  } vec_t;

  vec_t tbl[6];
  vec_t exp_q[$];

  hdmi_axi_addr_gen #(
    .X_SIZE(X), .Y_SIZE(Y), .BYTES_PER_PIXEL(BPP), .BURST_WORDS(BURST),
    .NUM_BUFFERS(NB), .BUF_BASE(BASE), .BUF_STRIDE(STRIDE),
    .LINE_PITCH(PITCH), .FIFO_THRESH(THRESH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .buf_sel(buf_sel),
    .fifo_available(fifo_available), .busy(busy), .kick(kick),
    .read_addr(read_addr), .read_num(read_num), .frame_active(frame_active),
    .line_done(line_done), .frame_done(frame_done), .cur_line(cur_line)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] bsel);
    buf_sel = bsel;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_kick(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (kick) seen = 1'b1;
      else tick();
    end
  endtask

  // Called with kick freshly up (ISSUE); step into WAIT, then accept for one cycle.
  task automatic accept();
    tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
  endtask

  // Expected command list for one frame, straight from the addressing rules.
  function automatic void build_frame(input logic [1:0] bsel);
    int unsigned b, col, n, ml;
    exp_q.delete();
    b = (bsel > NB - 1) ? NB - 1 : int'(bsel);
    for (int unsigned l = 0; l < Y; l++) begin
      col = 0;
      while (col < X) begin
        vec_t v;
        n = (X - col < BURST) ? X - col : BURST;
`ifdef HDMI_AXI_ADDR_GEN_VFLIP_EN
        ml = Y - 1 - l;
`else
        ml = l;
`endif
        v.addr = BASE + b * STRIDE + ml * PITCH + col * BPP;
        v.num  = n;
        v.line = 16'(l);
        v.ld   = (col + n == X);
        v.fd   = (col + n == X) && (l == Y - 1);
        exp_q.push_back(v);
        col += n;
      end
    end
  endfunction

  task automatic run_model_frame(input logic [1:0] bsel);
    bit seen;
    build_frame(bsel);
    apply_stimulus(bsel);
    for (int k = 0; k < exp_q.size(); k++) begin
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
        if (kick) seen = 1'b1;
        else begin
          fifo_available = ($urandom_range(0, 1) == 1) ? $urandom_range(0, THRESH - 1)
                                                       : $urandom_range(THRESH, THRESH + 3000);
          tick();
        end
      end
      check_output("rand_kick_seen", 32'(seen), 32'd1);
      if (!seen) return;
      check_output("rand_addr", read_addr, exp_q[k].addr);
      check_output("rand_num", read_num, exp_q[k].num);
      check_output("rand_line", 32'(cur_line), 32'(exp_q[k].line));
      repeat ($urandom_range(1, 4)) tick();
      busy = 1'b1;
      tick();
      busy = 1'b0;
      check_output("rand_line_done", 32'(line_done), 32'(exp_q[k].ld));
      check_output("rand_frame_done", 32'(frame_done), 32'(exp_q[k].fd));
    end
    check_output("rand_frame_end_idle", 32'(frame_active), 32'd0);
  endtask

  initial begin
    bit seen;

    tbl[0] = '{BASE + STRIDE + LO0 + 32'h000, 32'd256, 16'd0, 1'b0, 1'b0};
    tbl[1] = '{BASE + STRIDE + LO0 + 32'h400, 32'd256, 16'd0, 1'b0, 1'b0};
    tbl[2] = '{BASE + STRIDE + LO0 + 32'h800, 32'd88,  16'd0, 1'b1, 1'b0};
    tbl[3] = '{BASE + STRIDE + LO1 + 32'h000, 32'd256, 16'd1, 1'b0, 1'b0};
    tbl[4] = '{BASE + STRIDE + LO1 + 32'h400, 32'd256, 16'd1, 1'b0, 1'b0};
    tbl[5] = '{BASE + STRIDE + LO1 + 32'h800, 32'd88,  16'd1, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; buf_sel = 2'd0;
    fifo_available = 32'd0; busy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_output("reset_kick", 32'(kick), 32'd0);
    check_output("reset_addr", read_addr, BASE);
    check_output("reset_num", read_num, 32'd0);
    check_output("reset_active", 32'(frame_active), 32'd0);
    check_output("reset_line", 32'(cur_line), 32'd0);
    check_output("reset_pulses", {30'd0, line_done, frame_done}, 32'd0);

    // Reference frame, buffer 1, with the two-cycle start latency.
    apply_stimulus(2'd1);
    check_output("latency_kick_c1", 32'(kick), 32'd0);
    check_output("latency_active", 32'(frame_active), 32'd1);
    tick();
    check_output("latency_kick_c2", 32'(kick), 32'd1);
    for (int i = 0; i < 6; i++) begin
      wait_kick(20, seen);
      check_output("tbl_kick_seen", 32'(seen), 32'd1);
      check_output("tbl_addr", read_addr, tbl[i].addr);
      check_output("tbl_num", read_num, tbl[i].num);
      check_output("tbl_line", 32'(cur_line), 32'(tbl[i].line));
      accept();
      check_output("tbl_line_done", 32'(line_done), 32'(tbl[i].ld));
      check_output("tbl_frame_done", 32'(frame_done), 32'(tbl[i].fd));
    end
    check_output("tbl_idle_after_frame", 32'(frame_active), 32'd0);

    // buf_sel beyond the buffer count clamps to the last buffer.
    apply_stimulus(2'd3);
    wait_kick(10, seen);
    check_output("clamp_addr", read_addr, tbl[0].addr);
    accept();
    // start while busy with a frame is ignored.
    buf_sel = 2'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_kick(10, seen);
    check_output("ignored_start_addr", read_addr, tbl[1].addr);
    // Busy held high: one accept only, no re-issue over a busy master.
    tick();
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("busy_hold_addr", read_addr, tbl[1].addr);
      check_output("busy_hold_kick", 32'(kick), 32'd0);
    end
    busy = 1'b0;
    wait_kick(10, seen);
    check_output("busy_hold_next_addr", read_addr, tbl[2].addr);
    check_output("busy_hold_next_num", read_num, tbl[2].num);
    // Abort in WAIT: kick holds until accepted, then IDLE with no pulses.
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_wait_kick_hold1", 32'(kick), 32'd1);
    tick();
    check_output("abort_wait_kick_hold2", 32'(kick), 32'd1);
    check_output("abort_wait_addr_hold", read_addr, tbl[2].addr);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    check_output("abort_wait_kick_drop", 32'(kick), 32'd0);
    check_output("abort_wait_active", 32'(frame_active), 32'd0);
    check_output("abort_wait_pulses", {30'd0, line_done, frame_done}, 32'd0);
    tick();
    check_output("abort_wait_no_reissue", 32'(kick), 32'd0);
    // Restart after abort begins from line 0.
    run_model_frame(2'd0);

    // FIFO threshold gating: equal blocks, one below lets the burst go.
    fifo_available = THRESH;
    apply_stimulus(2'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("thresh_block_kick", 32'(kick), 32'd0);
    end
    fifo_available = THRESH - 1;
    tick();
    if (!kick) tick();
    check_output("thresh_release_kick", 32'(kick), 32'd1);
    // Abort in ISSUE.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_issue_kick", 32'(kick), 32'd0);
    check_output("abort_issue_active", 32'(frame_active), 32'd0);
    // Abort in GATE.
    fifo_available = THRESH;
    apply_stimulus(2'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_gate_active", 32'(frame_active), 32'd0);
    fifo_available = 32'd0;
    tick();
    check_output("abort_gate_kick", 32'(kick), 32'd0);
    // start together with abort in IDLE: stays idle.
    abort = 1'b1;
    apply_stimulus(2'd1);
    abort = 1'b0;
    check_output("start_abort_active", 32'(frame_active), 32'd0);
    tick();
    tick();
    check_output("start_abort_kick", 32'(kick), 32'd0);

    // Reset mid-frame.
    apply_stimulus(2'd1);
    wait_kick(10, seen);
    accept();
    wait_kick(10, seen);
    rst = 1'b1;
    tick();
    check_output("midrst_kick", 32'(kick), 32'd0);
    check_output("midrst_addr", read_addr, BASE);
    check_output("midrst_active", 32'(frame_active), 32'd0);
    rst = 1'b0;
    tick();
    check_output("midrst_stays_idle", 32'(kick), 32'd0);

    // Randomized frames against the model.
    for (int f = 0; f < 12; f++) begin
      run_model_frame(2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
